// File: rtl/bp_stream_io_arbiter_pkg.sv
// ============================================================================
//  Module   : bp_stream_io_arbiter_pkg
//  Brief    : Shared constants and helpers for the stream-host IO arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_stream_io_arbiter_pkg;

    // Default width of one single-flit bedrock memory message.
    localparam int c_cce_mem_msg_width = 64;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : bp_stream_io_arbiter_pkg

`default_nettype wire

// File: rtl/bp_stream_io_arbiter_if.sv
// ============================================================================
//  Module   : bp_stream_io_arbiter_if
//  Brief    : Requester-side and chip-side command/response bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bp_stream_io_arbiter_if
    import bp_stream_io_arbiter_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = c_cce_mem_msg_width,
    parameter int max_outstanding_p = 4
) ();

    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;
    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_ready_i;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_yumi_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_ready_o;
    logic [cnt_width_lp-1:0]          outstanding_o;
    logic                             error_o;

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        input  io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        output req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_ready_o, outstanding_o, error_o
    );

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        output io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        input  req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_ready_o, outstanding_o, error_o
    );

endinterface : bp_stream_io_arbiter_if

`default_nettype wire

// File: rtl/bp_stream_io_tag_fifo.sv
// ============================================================================
//  Module   : bp_stream_io_tag_fifo
//  Brief    : Small in-order FIFO of source IDs for commands awaiting a response.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_stream_io_tag_fifo
    import bp_stream_io_arbiter_pkg::*;
#(
    parameter int depth_p = 4,
    parameter int width_p = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           push_i,
    input  logic [width_p-1:0]             data_i,
    input  logic                           pop_i,
    output logic [width_p-1:0]             data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(depth_p+1)-1:0]   count_o
);

    localparam int ptr_width_lp = safe_clog2(depth_p);
    localparam int cnt_width_lp = $clog2(depth_p + 1);

    logic [width_p-1:0]      mem_q [depth_p];
    logic [width_p-1:0]      mem_d [depth_p];
    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    push_ok, pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(depth_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign full_o  = (count_q == cnt_width_lp'(depth_p));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : bp_stream_io_tag_fifo

`default_nettype wire

// File: rtl/bp_stream_io_arbiter.sv
// ============================================================================
//  Module   : bp_stream_io_arbiter
//  Brief    : Round-robin sharing of the host IO command channel; responses
//             are steered back to their issuer in order via a source-ID FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_stream_io_arbiter
    import bp_stream_io_arbiter_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = c_cce_mem_msg_width,
    parameter int max_outstanding_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_stream_io_arbiter_if.slave    io
);

    localparam int lg_req_lp    = safe_clog2(num_req_p);
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

    logic [lg_req_lp-1:0]    rr_ptr_q, rr_ptr_d;
    logic [lg_req_lp-1:0]    lock_id_q, lock_id_d;
    logic                    lock_q, lock_d;
    logic                    error_q, error_d;
    logic [lg_req_lp-1:0]    grant_id;
    logic [lg_req_lp-1:0]    head_id;
    logic                    found;
    logic                    cmd_v, cmd_fire;
    logic                    resp_ready, resp_fire;
    logic                    fifo_full, fifo_empty;
    logic [cnt_width_lp-1:0] fifo_count;
    logic [num_req_p-1:0]    cmd_yumi, resp_v;

    always_comb begin : grant_select
        grant_id = rr_ptr_q;
        found    = 1'b0;
        if (lock_q) begin
            grant_id = lock_id_q;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (!found && io.req_cmd_v_i[(int'(rr_ptr_q) + i) % num_req_p]) begin
                    found    = 1'b1;
                    grant_id = lg_req_lp'((int'(rr_ptr_q) + i) % num_req_p);
                end
            end
        end
    end

    // Gated by reset so the channel reads idle the instant reset asserts,
    // even while requesters still hold their valids.
    assign cmd_v    = reset_n_i & (|io.req_cmd_v_i) & ~fifo_full;
    assign cmd_fire = cmd_v & io.io_cmd_yumi_i;

    always_comb begin : cmd_ctrl
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        cmd_yumi  = '0;
        if (cmd_fire) begin
            cmd_yumi[grant_id] = 1'b1;
            rr_ptr_d = (grant_id == lg_req_lp'(num_req_p - 1)) ? '0
                                                                : grant_id + lg_req_lp'(1);
            lock_d   = 1'b0;
        end else if (cmd_v) begin
            lock_d    = 1'b1;
            lock_id_d = grant_id;
        end
    end

    assign resp_ready = ~fifo_empty & io.req_resp_ready_i[head_id];
    assign resp_fire  = io.io_resp_v_i & resp_ready;
    assign error_d    = error_q | (io.io_resp_v_i & fifo_empty);

    always_comb begin : resp_steer
        resp_v = '0;
        if (io.io_resp_v_i && !fifo_empty) begin
            resp_v[head_id] = 1'b1;
        end
    end

    bp_stream_io_tag_fifo #(
        .depth_p (max_outstanding_p),
        .width_p (lg_req_lp)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (cmd_fire),
        .data_i    (grant_id),
        .pop_i     (resp_fire),
        .data_o    (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            error_q   <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            error_q   <= error_d;
        end
    end

    assign io.io_cmd_o        = io.req_cmd_i[int'(grant_id)*msg_width_p +: msg_width_p];
    assign io.io_cmd_v_o      = cmd_v;
    assign io.req_cmd_yumi_o  = cmd_yumi;
    assign io.req_resp_o      = io.io_resp_i;
    assign io.req_resp_v_o    = resp_v;
    assign io.io_resp_ready_o = resp_ready;
    assign io.outstanding_o   = fifo_count;
    assign io.error_o         = error_q;

`ifndef SYNTHESIS
    a_yumi_needs_valid : assert property (
        @(posedge clk_i) disable iff (!reset_n_i) io.io_cmd_yumi_i |-> io.io_cmd_v_o
    );
`endif

endmodule : bp_stream_io_arbiter

`default_nettype wire
